mxv_stream_loader: RTL and testbench

- Upstream stage of the combinational mxv block.
- Accepts a serial stream of signed words over a valid/ready handshake and assembles them into the matrix[ROWS][COLS] and vector[ROWS] arrays that mxv consumes.
  - Matrix elements arrive in row-major order.
  - The vector follows the matrix.
- Presents a complete operand set with out_valid, holds it stable until out_ack, then reloads.

---
 rtl/mxv_stream_loader.sv | 147 ++++++++++++++
 tb/tb_mxv_stream_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mxv_stream_loader.sv
// Serial-to-parallel operand loader for mxv: fills matrix (row-major) then vector
// from a valid/ready stream, then holds the set until the consumer acknowledges it.
module mxv_stream_loader #(
    parameter int ROWS = 3,
    parameter int COLS = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_last,
    output logic signed [DW-1:0] matrix [ROWS][COLS],
    output logic signed [DW-1:0] vector [ROWS],
    output logic                 out_valid,
    input  logic                 out_ack,
    output logic                 frame_err
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic [1:0] {
        LOAD_M = 2'd0,
        LOAD_V = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         vidx_q, vidx_d;
    logic                  frame_err_q, frame_err_d;
    logic                  wr_m, wr_v;
    logic                  xfer;
    logic signed [DW-1:0]  matrix_q [ROWS][COLS];
    logic signed [DW-1:0]  vector_q [ROWS];

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q == FULL);
    assign frame_err = frame_err_q;
    assign xfer      = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        vidx_d      = vidx_q;
        frame_err_d = frame_err_q;
        wr_m        = 1'b0;
        wr_v        = 1'b0;
        case (state_q)
            LOAD_M: begin
                if (xfer) begin
                    if (in_last) begin
                        // Premature end of frame: drop what was collected and resync.
                        frame_err_d = 1'b1;
                        row_d       = '0;
                        col_d       = '0;
                    end else begin
                        wr_m = 1'b1;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                row_d   = '0;
                                state_d = LOAD_V;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            LOAD_V: begin
                if (xfer) begin
                    if (vidx_q == ROW_LAST) begin
                        // A missing in_last is flagged but the data is still presented.
                        wr_v    = 1'b1;
                        vidx_d  = '0;
                        state_d = FULL;
                        if (!in_last) begin
                            frame_err_d = 1'b1;
                        end
                    end else if (in_last) begin
                        frame_err_d = 1'b1;
                        vidx_d      = '0;
                        state_d     = LOAD_M;
                    end else begin
                        wr_v   = 1'b1;
                        vidx_d = vidx_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (out_ack) begin
                    state_d = LOAD_M;
                end
            end
            default: begin
                state_d = LOAD_M;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD_M;
            row_q       <= '0;
            col_q       <= '0;
            vidx_q      <= '0;
            frame_err_q <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                vector_q[r] <= '0;
                for (int c = 0; c < COLS; c++) begin
                    matrix_q[r][c] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            vidx_q      <= vidx_d;
            frame_err_q <= frame_err_d;
            if (wr_m) begin
                matrix_q[row_q][col_q] <= in_data;
            end
            if (wr_v) begin
                vector_q[vidx_q] <= in_data;
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            assign vector[gi] = vector_q[gi];
            for (gj = 0; gj < COLS; gj++) begin : g_col
                assign matrix[gi][gj] = matrix_q[gi][gj];
            end
        end
    endgenerate

endmodule

// File: tb/tb_mxv_stream_loader.sv
// Directed/randomized bench for mxv_stream_loader against a word-count based
// reference model of frame assembly, framing errors and the hold/ack handshake.
module tb_mxv_stream_loader;
    localparam int ROWS = 3;
    localparam int COLS = 5;
    localparam int DW   = 32;
    localparam int RC   = ROWS * COLS;
    localparam int NW   = RC + ROWS;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 in_last;
    logic signed [DW-1:0] matrix [ROWS][COLS];
    logic signed [DW-1:0] vector [ROWS];
    logic                 out_valid;
    logic                 out_ack;
    logic                 frame_err;

    int checks = 0;
    int errors = 0;

    // Reference model: frame position counter plus expected contents.
    logic [DW-1:0] m_mat [ROWS][COLS];
    logic [DW-1:0] m_vec [ROWS];
    int            m_k;
    bit            m_full;
    bit            m_err;

    logic [DW-1:0] words [NW];

    mxv_stream_loader #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .matrix    (matrix),
        .vector    (vector),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_k    = 0;
        m_full = 1'b0;
        m_err  = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            m_vec[r] = '0;
            for (int c = 0; c < COLS; c++) m_mat[r][c] = '0;
        end
    endtask

    // One clock cycle: drive, check in_ready, advance model, check flags after the edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l, input logic a);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        out_ack  = a;
        chk("in_ready", 32'(in_ready), 32'(!m_full));
        if (m_full) begin
            if (a) m_full = 1'b0;
        end else if (v) begin
            if (m_k == NW - 1) begin
                m_vec[ROWS-1] = d;
                m_full = 1'b1;
                if (!l) m_err = 1'b1;
                m_k = 0;
            end else if (l) begin
                m_err = 1'b1;
                m_k   = 0;
            end else begin
                if (m_k < RC) m_mat[m_k / COLS][m_k % COLS] = d;
                else          m_vec[m_k - RC] = d;
                m_k++;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("frame_err", 32'(frame_err), 32'(m_err));
    endtask

    task automatic check_arrays(input string tag);
        for (int r = 0; r < ROWS; r++) begin
            chk({tag, "_vec"}, vector[r], m_vec[r]);
            for (int c = 0; c < COLS; c++) chk({tag, "_mat"}, matrix[r][c], m_mat[r][c]);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ack  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_frame_err", 32'(frame_err), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        check_arrays("rst");
    endtask

    // Sends words[0..n-1]; in_last on index lastpos (-1 = never); optional random throttling.
    task automatic send(input int n, input int lastpos, input bit throttle);
        int guard = 0;
        for (int i = 0; i < n; i++) begin
            bit done = 1'b0;
            while (!done) begin
                logic v;
                v = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
                cycle(v, words[i], (i == lastpos), 1'b0);
                done = v;
                guard++;
                if (guard > 2000) begin
                    errors++;
                    $display("FAIL send_timeout: observed %0d cycles required < 2000", guard);
                    return;
                end
            end
        end
    endtask

    task automatic nominal_words();
        for (int i = 0; i < RC; i++) words[i] = 32'(i + 1);
        for (int i = 0; i < ROWS; i++) words[RC + i] = 32'(i + 1);
    endtask

    task automatic check_mxv();
        longint res;
        for (int c = 0; c < COLS; c++) begin
            res = 0;
            for (int r = 0; r < ROWS; r++) res += longint'(vector[r]) * longint'(matrix[r][c]);
            chk("mxv_result", 32'(res), 32'(46 + 6 * c));
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        out_ack  = 1'b0;
        @(posedge clk);
        do_reset();

        // Nominal frame, ack held low.
        nominal_words();
        send(NW, NW - 1, 1'b0);
        chk("nom_out_valid", 32'(out_valid), 32'(1));
        check_arrays("nom");
        chk("nom_m00", matrix[0][0], 32'd1);
        chk("nom_m24", matrix[2][4], 32'd15);
        chk("nom_v2", vector[2], 32'd3);
        check_mxv();

        // Hold with pending input, then ack; 99 lands in matrix[0][0] afterwards.
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'd99, 1'b0, 1'b0);
        check_arrays("hold");
        cycle(1'b1, 32'd99, 1'b0, 1'b1);
        chk("ack_out_valid", 32'(out_valid), 32'(0));
        cycle(1'b1, 32'd99, 1'b0, 1'b0);
        chk("reload_m00", matrix[0][0], 32'd99);
        check_arrays("reload");

        // Reset partway through a frame (10 words in total).
        for (int i = 0; i < 9; i++) cycle(1'b1, 32'(200 + i), 1'b0, 1'b0);
        do_reset();
        nominal_words();
        send(NW, NW - 1, 1'b0);
        check_arrays("post_rst");
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Throttled input with negatives and random data.
        nominal_words();
        words[3]  = 32'hFFFF_FFFF;
        words[9]  = 32'h8000_0000;
        words[16] = 32'h8000_0000;
        words[12] = $urandom;
        send(NW, NW - 1, 1'b1);
        chk("thr_m03", matrix[0][3], 32'hFFFF_FFFF);
        chk("thr_m14", matrix[1][4], 32'h8000_0000);
        check_arrays("thr");
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Early in_last on word 7, then a clean random frame.
        for (int i = 0; i < NW; i++) words[i] = $urandom;
        send(7, 6, 1'b0);
        chk("early_err", 32'(frame_err), 32'(1));
        chk("early_valid", 32'(out_valid), 32'(0));
        send(NW, NW - 1, 1'b1);
        chk("early_clean_valid", 32'(out_valid), 32'(1));
        check_arrays("early_clean");
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Missing in_last on an otherwise complete frame.
        do_reset();
        for (int i = 0; i < NW; i++) words[i] = $urandom;
        send(NW, -1, 1'b0);
        chk("miss_valid", 32'(out_valid), 32'(1));
        chk("miss_err", 32'(frame_err), 32'(1));
        check_arrays("miss");
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
